// File: rtl/mux_channel_scanner_if.sv
// Bus between the channel scanner and whatever owns the mux inputs.
// The slave side is the scanner; the master side drives enable, mask
// and the mux output and observes the select lines and snapshots.
interface mux_channel_scanner_if;
    logic       en;
    logic [3:0] chan_mask;
    logic       y_in;
    logic [1:0] sel;
    logic [3:0] sample;
    logic       frame_valid;
    logic       busy;

    modport master (
        output en, chan_mask, y_in,
        input  sel, sample, frame_valid, busy
    );

    modport slave (
        input  en, chan_mask, y_in,
        output sel, sample, frame_valid, busy
    );
endinterface

// File: rtl/mux_channel_scanner.sv
// Time-division scanner for a 4-to-1 mux: steps the select lines through
// the enabled channels, dwells DWELL cycles on each, samples the mux
// output at the end of each dwell and publishes one 4-bit snapshot per
// completed frame.
module mux_channel_scanner #(
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_channel_scanner_if.slave bus
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    mask_reg, mask_next;
    logic [3:0]    shadow_reg, shadow_next;
    logic [1:0]    sel_reg, sel_next;
    logic [3:0]    sample_reg, sample_next;
    logic          fv_reg, fv_next;

    // Enabled channels strictly above the one currently selected.
    logic [3:0] above_mask;
    // Shadow with the current channel's value folded in at a capture edge.
    logic [3:0] shadow_cap;
    logic       capture;
    logic       last_chan;

    // Index of the lowest set bit; callers guarantee m is non-zero.
    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) idx = 2'(k);
        end
        return idx;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_above
            assign above_mask[gi] = mask_reg[gi] && (sel_reg < 2'(gi));
        end
    endgenerate

    assign capture   = (cnt_reg == CNT_LAST);
    assign last_chan = (above_mask == 4'b0000);

    // Merge the live mux output into the shadow at the current channel.
    always_comb begin
        shadow_cap          = shadow_reg;
        shadow_cap[sel_reg] = bus.y_in;
    end

    // Next-state and datapath decisions for the scan sequencer.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mask_next   = mask_reg;
        shadow_next = shadow_reg;
        sel_next    = sel_reg;
        sample_next = sample_reg;
        fv_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                sel_next = 2'd0;
                cnt_next = '0;
                if (bus.en && (bus.chan_mask != 4'b0000)) begin
                    state_next  = SCAN;
                    mask_next   = bus.chan_mask;
                    shadow_next = 4'b0000;
                    sel_next    = lowest_bit(bus.chan_mask);
                end
            end
            SCAN: begin
                if (capture && last_chan) begin
                    // Frame complete: publish, then restart or go idle.
                    sample_next = shadow_cap;
                    shadow_next = shadow_cap;
                    fv_next     = 1'b1;
                    cnt_next    = '0;
                    if (bus.en) mask_next = bus.chan_mask;
                    if (bus.en && (bus.chan_mask != 4'b0000)) begin
                        shadow_next = 4'b0000;
                        sel_next    = lowest_bit(bus.chan_mask);
                    end else begin
                        state_next = IDLE;
                        sel_next   = 2'd0;
                    end
                end else if (!bus.en) begin
                    // Abort mid-frame: partial shadow is simply abandoned.
                    state_next = IDLE;
                    sel_next   = 2'd0;
                    cnt_next   = '0;
                end else if (capture) begin
                    shadow_next = shadow_cap;
                    sel_next    = lowest_bit(above_mask);
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = 2'd0;
                cnt_next   = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            mask_reg   <= 4'b0000;
            shadow_reg <= 4'b0000;
            sel_reg    <= 2'd0;
            sample_reg <= 4'b0000;
            fv_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            mask_reg   <= mask_next;
            shadow_reg <= shadow_next;
            sel_reg    <= sel_next;
            sample_reg <= sample_next;
            fv_reg     <= fv_next;
        end
    end

    assign bus.sel         = sel_reg;
    assign bus.sample      = sample_reg;
    assign bus.frame_valid = fv_reg;
    assign bus.busy        = (state_reg == SCAN);
endmodule

// File: tb/tb_mux_channel_scanner.sv
// Scoreboard bench for mux_channel_scanner: a DWELL=4 instance exercised
// with random frames plus abort, empty-mask and async-reset scenarios,
// and a DWELL=1 instance with a toggling channel 3.
module tb_mux_channel_scanner;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  s;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t sb1[$];
    exp_t e_mon;
    exp_t e_mon1;

    logic [3:0] data;
    logic [3:0] data1;
    logic [3:0] last_sample;

    mux_channel_scanner_if bus ();
    mux_channel_scanner_if bus1 ();

    // Behavioural 4-to-1 mux feeding each scanner.
    assign bus.y_in  = data[bus.sel];
    assign bus1.y_in = data1[bus1.sel];

    mux_channel_scanner #(.DWELL(D)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mux_channel_scanner #(.DWELL(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called #1 after the edge that latched mask m. Holds data d for the
    // frame, pre-loads the next frame's mask, and checks the select
    // sequence against the ordered list of enabled channels.
    task automatic do_frame(input logic [3:0] m, input logic [3:0] d, input logic [3:0] nxt);
        int   chans[$];
        int   c0;
        exp_t e;
        for (int k = 0; k < 4; k++) if (m[k]) chans.push_back(k);
        data      = d;
        bus.chan_mask = nxt;
        c0        = cyc;
        e.s       = d & m;
        e.c       = c0 + chans.size() * D;
        sb.push_back(e);
        last_sample = d & m;
        for (int t = 0; t < chans.size() * D; t++) begin
            @(negedge clk);
            chk("sel", 32'(bus.sel), 32'(chans[t / D]));
            chk("busy", 32'(bus.busy), 32'd1);
            @(posedge clk);
        end
        #1;
    endtask

    // Monitor for the DWELL=4 instance.
    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected: got sample %b expected no pulse (cycle %0d)", bus.sample, cyc);
            end else begin
                e_mon = sb.pop_front();
                $display("frame cycle %0d sample %b", cyc, bus.sample);
                chk("sample", 32'(bus.sample), 32'(e_mon.s));
                chk("frame_cycle", 32'(cyc), 32'(e_mon.c));
            end
        end
    end

    // Monitor for the DWELL=1 instance.
    always @(negedge clk) begin
        if (bus1.frame_valid === 1'b1) begin
            if (sb1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame1_unexpected: got sample %b expected no pulse (cycle %0d)", bus1.sample, cyc);
            end else begin
                e_mon1 = sb1.pop_front();
                $display("frame1 cycle %0d sample %b", cyc, bus1.sample);
                chk("sample1", 32'(bus1.sample), 32'(e_mon1.s));
                chk("frame1_cycle", 32'(cyc), 32'(e_mon1.c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] fm[8];
        logic [3:0] fd[8];
        logic [3:0] d;
        exp_t       e;

        bus.en         = 1'b0;
        bus.chan_mask  = 4'b0000;
        bus1.en        = 1'b0;
        bus1.chan_mask = 4'b0000;
        data           = 4'b0000;
        data1          = 4'b0000;
        last_sample    = 4'b0000;

        // Reset values.
        @(negedge clk);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_sample", 32'(bus.sample), 32'd0);
        chk("rst_fv", 32'(bus.frame_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed full and skip masks, then random frames back to back.
        fm[0] = 4'b1111; fd[0] = 4'b1101;
        fm[1] = 4'b0101; fd[1] = 4'b1101;
        for (int i = 2; i < 8; i++) begin
            fm[i] = 4'($urandom_range(1, 15));
            fd[i] = 4'($urandom);
        end
        data          = fd[0];
        bus.chan_mask = fm[0];
        bus.en        = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            do_frame(fm[i], fd[i], (i < 7) ? fm[i + 1] : 4'b0000);
        end
        @(negedge clk);
        #1;
        chk("idle_after_frames", 32'(bus.busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Abort: drop en six cycles into a full-mask frame.
        @(posedge clk);
        #1;
        data          = 4'($urandom);
        bus.chan_mask = 4'b1111;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 bus.en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_sel", 32'(bus.sel), 32'd0);
        chk("abort_sample", 32'(bus.sample), 32'(last_sample));
        repeat (20) @(posedge clk);

        // Empty mask with en high: never starts.
        #1;
        bus.chan_mask = 4'b0000;
        bus.en        = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            chk("empty_busy", 32'(bus.busy), 32'd0);
            chk("empty_fv", 32'(bus.frame_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        d             = 4'($urandom);
        bus.chan_mask = 4'b1000;
        @(posedge clk);
        #1;
        do_frame(4'b1000, d, 4'b0000);

        // Asynchronous reset mid-dwell, then a clean restart.
        @(posedge clk);
        #1;
        bus.chan_mask = 4'b1111;
        data          = 4'($urandom);
        @(posedge clk);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        sb.delete();
        last_sample = 4'b0000;
        chk("arst_sel", 32'(bus.sel), 32'd0);
        chk("arst_sample", 32'(bus.sample), 32'd0);
        chk("arst_fv", 32'(bus.frame_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        #1 rst = 1'b0;
        d    = 4'($urandom);
        data = d;
        @(posedge clk);
        #1;
        do_frame(4'b1111, d, 4'b0000);
        @(negedge clk);
        #1;
        chk("sb_drained2", 32'(sb.size()), 32'd0);

        // DWELL=1 instance: channel 3 only, input toggling every cycle.
        bus.en         = 1'b0;
        bus1.en        = 1'b1;
        bus1.chan_mask = 4'b1000;
        data1          = 4'($urandom);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            #1;
            data1[3] = ~data1[3];
            if (i == 19) bus1.en = 1'b0;
            e.s = {data1[3], 3'b000};
            e.c = cyc + 1;
            sb1.push_back(e);
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        chk("idle1_busy", 32'(bus1.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
